alu181_seq_engine: RTL and testbench

- Parametrised, sequenced successor to the fixed two-slice 8-bit 74181 datapath.
- Processes a WIDTH-bit operation one 4-bit 74181 slice per clock, LSB nibble first, through a single time-shared slice instance; a registered carry links consecutive nibbles.
- Adds a start/busy/done handshake, an internal accumulator (the result can feed back as operand A), and whole-word zero and equal flags.
- Sits between the SPI register file (config regs drive start/operands; status regs read f and flags) and the 7-segment decoder.

---
 rtl/alu181_seq_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_alu181_seq_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu181_seq_engine.sv
// ---------------------------------------------------------------------------
// alu181_seq_engine
//
// Sequenced WIDTH-bit 74181-style ALU. One 4-bit slice is time-shared across
// the word: nibble 0 is processed on the first RUN edge and nibble NIB-1 on
// the last. A registered carry links consecutive nibbles. The result register
// f doubles as an accumulator that can be fed back as operand A.
//
// Handshake: a start pulse seen in IDLE or DONE is accepted on that rising
// edge. busy is high for exactly NIB cycles after acceptance. done is high
// for the one cycle after the commit edge. start while busy is dropped and
// is not queued.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      request an operation (sampled in IDLE/DONE only)
//   s, m       74181 function select / mode (1 = logic, 0 = arithmetic)
//   cn         carry into nibble 0, active low (1 = no carry)
//   acc_sel    1: operand A = f register, 0: operand A = input a
//   acc_clr    clear f (and set zero) when not busy
//   a, b       operands
//   busy       nibbles being processed
//   done       one-cycle result-committed pulse
//   f          result / accumulator
//   cn_out     carry out of the final nibble, active low
//   equal      AND of every nibble's A=B output
//   zero       committed f is zero
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------

// One 4-bit 74181 slice, active-high data.
// w_x / w_y are the two per-bit terms the slice adds in arithmetic mode
// (w_y is always a subset of w_x, so w_y is the generate and w_x is the
// propagate). Logic mode suppresses the carries and inverts the half sum.
module alu181_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       aeqb
);

  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [4:0] w_c;

  assign w_x = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
  assign w_y = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});

  // Ripple carry, active-high internally.
  assign w_c[0] = ~cn;
  assign w_c[1] = w_y[0] | (w_x[0] & w_c[0]);
  assign w_c[2] = w_y[1] | (w_x[1] & w_c[1]);
  assign w_c[3] = w_y[2] | (w_x[2] & w_c[2]);
  assign w_c[4] = w_y[3] | (w_x[3] & w_c[3]);

  assign f    = m ? ~(w_x ^ w_y) : (w_x ^ w_y ^ w_c[3:0]);
  assign cn4  = ~w_c[4];
  // The A=B pin of the 74181 is the AND of the F outputs.
  assign aeqb = &f;

endmodule

module alu181_seq_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn,
  input  logic             acc_sel,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cn_out,
  output logic             equal,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  // Captured operation
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_s;
  logic             r_m;
  // Working registers
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_eq;
  logic [WIDTH-1:0] r_work;
  // Committed outputs
  logic [WIDTH-1:0] r_f;
  logic             r_cn_out;
  logic             r_equal;
  logic             r_zero;

  logic             w_idle_like;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_opa_cap;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_slice_f;
  logic             w_slice_cn4;
  logic             w_slice_eq;
  logic [WIDTH-1:0] w_work_next;

  assign w_idle_like = (r_state != ST_RUN);
  assign w_accept    = w_idle_like && start;
  assign w_last      = (r_idx == IW'(NIB - 1));

  // A clear issued together with start takes effect first, so a fed-back
  // operand sees zero rather than the old accumulator.
  assign w_opa_cap = acc_sel ? (acc_clr ? '0 : r_f) : a;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = start ? ST_RUN : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = r_state;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Nibble selection for the shared slice
  // -------------------------------------------------------------------------
  always_comb begin
    w_nib_a = '0;
    w_nib_b = '0;
    for (int n = 0; n < NIB; n++) begin
      if (r_idx == IW'(n)) begin
        w_nib_a = r_opa[4*n +: 4];
        w_nib_b = r_b[4*n +: 4];
      end
    end
  end

  alu181_slice u_slice (
    .a    (w_nib_a),
    .b    (w_nib_b),
    .s    (r_s),
    .m    (r_m),
    .cn   (r_carry),
    .f    (w_slice_f),
    .cn4  (w_slice_cn4),
    .aeqb (w_slice_eq)
  );

  // Work register with the current nibble merged in; on the last step this
  // is the complete result.
  always_comb begin
    w_work_next = r_work;
    for (int n = 0; n < NIB; n++) begin
      if (r_idx == IW'(n)) begin
        w_work_next[4*n +: 4] = w_slice_f;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa    <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_m      <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_eq     <= 1'b0;
      r_work   <= '0;
      r_f      <= '0;
      r_cn_out <= 1'b0;
      r_equal  <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_idle_like) begin
      if (acc_clr) begin
        r_f    <= '0;
        r_zero <= 1'b1;
      end
      if (w_accept) begin
        r_opa   <= w_opa_cap;
        r_b     <= b;
        r_s     <= s;
        r_m     <= m;
        r_carry <= cn;
        r_idx   <= '0;
        r_eq    <= 1'b1;
      end
    end else begin
      r_work  <= w_work_next;
      r_carry <= w_slice_cn4;
      r_eq    <= r_eq & w_slice_eq;
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_f      <= w_work_next;
        r_cn_out <= w_slice_cn4;
        r_equal  <= r_eq & w_slice_eq;
        r_zero   <= (w_work_next == '0);
      end
    end
  end

  assign f      = r_f;
  assign cn_out = r_cn_out;
  assign equal  = r_equal;
  assign zero   = r_zero;

endmodule

// File: tb/tb_alu181_seq_engine.sv
// ---------------------------------------------------------------------------
// tb_alu181_seq_engine
//
// Self-checking bench for alu181_seq_engine (WIDTH = 16). The 74181 behaviour
// is modelled from its function table over the whole word; expected results
// are queued at issue time and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_alu181_seq_engine;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   s = '0;
  logic         m = 1'b0;
  logic         cn = 1'b1;
  logic         acc_sel = 1'b0;
  logic         acc_clr = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] f;
  logic         cn_out;
  logic         equal;
  logic         zero;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu181_seq_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s         (s),
    .m         (m),
    .cn        (cn),
    .acc_sel   (acc_sel),
    .acc_clr   (acc_clr),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .f         (f),
    .cn_out    (cn_out),
    .equal     (equal),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_flag_q[$];   // {cn_out, equal, zero}
  int           exp_cyc_q[$];

  logic [W-1:0] model_f  = '0;
  logic         model_cn = 1'b0;
  logic         model_eq = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
  endtask

  // Whole-word 74181 function table, active-high data, cn active low.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [3:0] sv,
                       input logic mv, input logic cv, output logic [W-1:0] fo,
                       output logic co, output logic eo, output logic zo);
    logic [W:0]   ea, eb, enb, ones, c, sum;
    logic [W-1:0] lf;
    ea   = {1'b0, av};
    eb   = {1'b0, bv};
    enb  = {1'b0, ~bv};
    ones = {1'b0, {W{1'b1}}};
    c    = {{W{1'b0}}, ~cv};
    case (sv)
      4'h0: sum = ea + c;
      4'h1: sum = (ea | eb) + c;
      4'h2: sum = (ea | enb) + c;
      4'h3: sum = ones + c;
      4'h4: sum = ea + (ea & enb) + c;
      4'h5: sum = (ea | eb) + (ea & enb) + c;
      4'h6: sum = ea + enb + c;
      4'h7: sum = (ea & enb) + ones + c;
      4'h8: sum = ea + (ea & eb) + c;
      4'h9: sum = ea + eb + c;
      4'hA: sum = (ea | enb) + (ea & eb) + c;
      4'hB: sum = (ea & eb) + ones + c;
      4'hC: sum = ea + ea + c;
      4'hD: sum = (ea | eb) + ea + c;
      4'hE: sum = (ea | enb) + ea + c;
      default: sum = ea + ones + c;
    endcase
    case (sv)
      4'h0: lf = ~av;
      4'h1: lf = ~(av | bv);
      4'h2: lf = ~av & bv;
      4'h3: lf = '0;
      4'h4: lf = ~(av & bv);
      4'h5: lf = ~bv;
      4'h6: lf = av ^ bv;
      4'h7: lf = av & ~bv;
      4'h8: lf = ~av | bv;
      4'h9: lf = ~(av ^ bv);
      4'hA: lf = bv;
      4'hB: lf = av & bv;
      4'hC: lf = '1;
      4'hD: lf = av | ~bv;
      4'hE: lf = av | bv;
      default: lf = av;
    endcase
    fo = mv ? lf : sum[W-1:0];
    co = ~sum[W];
    eo = &fo;
    zo = (fo == '0);
  endtask

  // Result monitor
  logic [W-1:0] mon_f;
  logic [2:0]   mon_fl;
  int           mon_c;
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_f  = exp_q.pop_front();
        mon_fl = exp_flag_q.pop_front();
        mon_c  = exp_cyc_q.pop_front();
        check("f",          32'(f),      32'(mon_f));
        check("cn_out",     32'(cn_out), 32'(mon_fl[2]));
        check("equal",      32'(equal),  32'(mon_fl[1]));
        check("zero",       32'(zero),   32'(mon_fl[0]));
        check("done_cycle", cyc,         mon_c);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks (called at a negedge with the DUT in IDLE or DONE)
  // -------------------------------------------------------------------------
  task automatic issue(input logic [3:0] s_i, input logic m_i, input logic cn_i,
                       input logic sel_i, input logic clr_i,
                       input logic [W-1:0] a_i, input logic [W-1:0] b_i);
    logic [W-1:0] opa, ef;
    logic ec, ee, ez;
    s = s_i; m = m_i; cn = cn_i; acc_sel = sel_i; acc_clr = clr_i;
    a = a_i; b = b_i; start = 1'b1;
    if (clr_i) model_f = '0;
    opa = sel_i ? model_f : a_i;
    model(opa, b_i, s_i, m_i, cn_i, ef, ec, ee, ez);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; acc_clr = 1'b0;
    // Operands are free to change once captured.
    a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = 1'($urandom);
    cn = 1'($urandom); acc_sel = 1'($urandom);
    model_f = ef; model_cn = ec; model_eq = ee;
    exp_q.push_back(ef);
    exp_flag_q.push_back({ec, ee, ez});
    exp_cyc_q.push_back(cyc + NIB);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic clr_only();
    acc_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_clr = 1'b0;
    model_f = '0;
    check("clr_f",      32'(f),      32'd0);
    check("clr_zero",   32'(zero),   32'd1);
    check("clr_cn_out", 32'(cn_out), 32'(model_cn));
    check("clr_equal",  32'(equal),  32'(model_eq));
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [W-1:0] prev_f;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_f",      32'(f),         32'd0);
    check("rst_cn_out", 32'(cn_out),    32'd0);
    check("rst_equal",  32'(equal),     32'd0);
    check("rst_zero",   32'(zero),      32'd0);
    check("rst_state",  32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // A plus B, latency and busy window
    issue(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h4321);
    for (int i = 1; i < NIB; i++) begin
      @(negedge clk);
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_f_held", 32'(f), 32'd0);
    end
    @(negedge clk);
    check("commit_done", 32'(done), 32'd1);
    check("commit_busy", 32'(busy), 32'd0);
    check("add_f",       32'(f),    32'h5555);
    check("add_cn_out",  32'(cn_out), 32'd1);
    check("add_zero",    32'(zero), 32'd0);
    @(negedge clk);
    check("done_pulse_len", 32'(done), 32'd0);

    // Carry through every nibble boundary
    issue(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    wait_done();
    check("wrap_f",      32'(f),      32'h0000);
    check("wrap_zero",   32'(zero),   32'd1);
    check("wrap_cn_out", 32'(cn_out), 32'd0);
    @(negedge clk);

    // A minus B minus 1 and the equal flag
    issue(4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'h00AA);
    wait_done();
    check("sub_eq_f",     32'(f),     32'hFFFF);
    check("sub_eq_equal", 32'(equal), 32'd1);
    @(negedge clk);
    issue(4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'h00AB);
    wait_done();
    check("sub_ne_f",     32'(f),     32'hFFFE);
    check("sub_ne_equal", 32'(equal), 32'd0);

    // XOR, then back-to-back start on the done cycle
    @(negedge clk);
    issue(4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 16'hF0F0, 16'hFF00);
    wait_done();
    check("xor_f", 32'(f), 32'h0FF0);
    issue(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222);
    wait_done();
    check("b2b_f", 32'(f), 32'h3333);

    // Accumulator
    clr_only();
    for (int i = 1; i <= 3; i++) begin
      issue(4'h9, 1'b0, 1'b1, 1'b1, 1'b0, W'($urandom), 16'h0005);
      wait_done();
      check("acc_f", 32'(f), 32'(5 * i));
    end
    // Clear together with start feeds zero as operand A
    issue(4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0007);
    wait_done();
    check("clr_start_f", 32'(f), 32'h0007);

    // start during RUN is ignored
    @(negedge clk);
    issue(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0200);
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("ign_start_f", 32'(f), 32'h0300);
    repeat (8) @(negedge clk);
    check("ign_start_idle", 32'(busy), 32'd0);

    // acc_clr during RUN is ignored
    prev_f = model_f;
    issue(4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA000, 16'h0A0A);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check("ign_clr_f_held", 32'(f), 32'(prev_f));
    wait_done();
    check("ign_clr_f", 32'(f), 32'hAA0A);

    // Reset at the second RUN edge
    @(negedge clk);
    issue(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); exp_flag_q.delete(); exp_cyc_q.delete();
    model_f = '0; model_cn = 1'b0; model_eq = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_f",    32'(f),    32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (8) @(negedge clk);
    issue(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1111);
    wait_done();
    check("after_abort_f", 32'(f), 32'h2345);

    // Random operations, some back-to-back
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            W'($urandom), W'($urandom));
      wait_done();
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
